// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and FSM state type for the instruction-fetch stage.
// Every file that needs them imports this package.
package if_fetch_pkg;

    localparam int ADDR_LEN       = 32;
    localparam int INST_LEN       = 32;
    localparam int STALL_LEN      = 6;
    localparam int ICACHE_IDX_LEN = 7;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    typedef enum logic {
        IF_IDLE  = 1'b0,
        IF_FETCH = 1'b1
    } if_state_e;

    // Bytes arrive little-endian, so the last byte is the most significant.
    function automatic logic [INST_LEN-1:0] inst_word(input logic [23:0] lo,
                                                      input logic [7:0]  hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache: one 32-bit word per line.
// Asynchronous read; synchronous write; only the valid bits are reset.
module icache_dm
    import if_fetch_pkg::*;
#(
    parameter int IDX_W  = ICACHE_IDX_LEN,
    parameter int ADDR_W = ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                hit,
    output logic [INST_LEN-1:0] rd_data,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [INST_LEN-1:0] wr_data
);

    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [INST_LEN-1:0] r_data [LINES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [TAG_W-1:0] w_wr_tag;
    logic             w_unused_lsb;

    assign w_rd_idx     = rd_addr[IDX_W+1:2];
    assign w_wr_idx     = wr_addr[IDX_W+1:2];
    assign w_rd_tag     = rd_addr[ADDR_W-1:IDX_W+2];
    assign w_wr_tag     = wr_addr[ADDR_W-1:IDX_W+2];
    assign w_unused_lsb = ^{rd_addr[1:0], wr_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are never looked at while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (we) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= wr_data;
        end
    end

    assign hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, direct-mapped I-cache lookup and a byte-serial
// miss fill from the memory controller; presents a zero bubble when not valid.
//
// state    | meaning
// IF_IDLE  | look up pc; present on hit, start a fill on miss
// IF_FETCH | collecting 4 bytes for mem_addr; drop=1 means pc was redirected meanwhile
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int IDX_W  = ICACHE_IDX_LEN,
    parameter int ADDR_W = ADDR_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [STALL_LEN-1:0] stall,
    input  logic                 jump_mistake,
    input  logic [ADDR_W-1:0]    jump_target,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_rvalid,
    input  logic [7:0]           mem_rdata,
    output logic [ADDR_W-1:0]    if_pc,
    output logic [INST_LEN-1:0]  if_inst,
    output logic                 stall_req
);

    if_state_e r_state;
    if_state_e w_state_nxt;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [1:0]          r_cnt;
    logic [1:0]          w_cnt_nxt;
    logic [23:0]         r_asm;
    logic [23:0]         w_asm_nxt;
    logic                r_drop;
    logic                w_drop_nxt;
    logic                r_mem_req;
    logic                w_mem_req_nxt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;

    logic                w_hit;
    logic [INST_LEN-1:0] w_line;
    logic                w_fill;
    logic                w_we;
    logic [INST_LEN-1:0] w_fill_data;
    logic                w_present;
    logic                w_unused_stall;

    assign w_unused_stall = ^stall[STALL_LEN-1:1];

    icache_dm #(
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (r_pc),
        .hit     (w_hit),
        .rd_data (w_line),
        .we      (w_we),
        .wr_addr (r_mem_addr),
        .wr_data (w_fill_data)
    );

    assign w_fill_data = inst_word(r_asm, mem_rdata);
    assign w_we        = w_fill && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IF_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_asm_nxt      = r_asm;
        w_drop_nxt     = r_drop;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_fill         = DISABLE;

        case (r_state)
            IF_IDLE: begin
                if (jump_mistake) begin
                    w_pc_nxt = jump_target;
                end else if (w_hit) begin
                    if (!stall[0]) begin
                        w_pc_nxt = r_pc + ADDR_W'(4);
                    end
                end else begin
                    w_state_nxt    = IF_FETCH;
                    w_mem_req_nxt  = ENABLE;
                    w_mem_addr_nxt = {r_pc[ADDR_W-1:2], 2'b00};
                    w_cnt_nxt      = 2'd0;
                end
            end
            IF_FETCH: begin
                // The fill always runs to completion; a redirect only moves pc.
                if (jump_mistake) begin
                    w_pc_nxt   = jump_target;
                    w_drop_nxt = ENABLE;
                end
                if (mem_rvalid) begin
                    if (r_cnt == 2'd3) begin
                        w_fill        = ENABLE;
                        w_mem_req_nxt = DISABLE;
                        w_state_nxt   = IF_IDLE;
                        w_drop_nxt    = DISABLE;
                        w_cnt_nxt     = 2'd0;
                    end else begin
                        case (r_cnt)
                            2'd0:    w_asm_nxt[7:0]   = mem_rdata;
                            2'd1:    w_asm_nxt[15:8]  = mem_rdata;
                            default: w_asm_nxt[23:16] = mem_rdata;
                        endcase
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end
            default: w_state_nxt = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_cnt      <= 2'd0;
            r_asm      <= '0;
            r_drop     <= DISABLE;
            r_mem_req  <= DISABLE;
            r_mem_addr <= '0;
        end else if (rdy) begin
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_asm      <= w_asm_nxt;
            r_drop     <= w_drop_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    assign w_present = (r_state == IF_IDLE) && !r_drop && w_hit;

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign if_pc     = w_present ? r_pc : '0;
    assign if_inst   = w_present ? w_line : ZERO_WORD;
    assign stall_req = !w_present && !rst;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a byte-serial memory responder, a line-address cache model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int LINES = 128;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rdy = 1'b1;
    logic [STALL_LEN-1:0] stall = '0;
    logic                 jump_mistake = 1'b0;
    logic [31:0]          jump_target = '0;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_rvalid = 1'b0;
    logic [7:0]           mem_rdata = '0;
    logic [31:0]          if_pc;
    logic [31:0]          if_inst;
    logic                 stall_req;

    int checks = 0;
    int errors = 0;
    bit drv_auto = 1'b0;
    bit drv_go = 1'b0;
    int drv_pct = 60;
    int drv_cnt = 0;

    always #5 clk = ~clk;

    if_fetch #(.IDX_W(7), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall        (stall),
        .jump_mistake (jump_mistake),
        .jump_target  (jump_target),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .stall_req    (stall_req)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0513;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ (a >> 3);
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = mem_word(a) >> (8 * k);
        return w[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: supplies bytes of mem_word(mem_addr) in little-endian order.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && rdy && mem_req && mem_rvalid) drv_cnt++;
            #2;
            if (rst || !mem_req) drv_cnt = 0;
            if (mem_req && !rst && (drv_auto ? ($urandom_range(99) < drv_pct) : drv_go)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_byte(mem_addr, drv_cnt);
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 8'($urandom);
            end
        end
    end

    // Reference model: cache held as line addresses, fill as a transaction.
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] m_pc = '0;
    logic [31:0] m_faddr = '0;
    logic [31:0] m_word = '0;
    bit          m_busy = 1'b0;
    int          m_n = 0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(LINES));
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_line[line_of(a)] == a / 32'd4);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            m_pc = '0; m_faddr = '0; m_busy = 1'b0; m_n = 0; m_word = '0;
        end else if (rdy) begin
            if (m_busy) begin
                if (mem_rvalid) begin
                    m_word = m_word | (32'(mem_rdata) << (8 * m_n));
                    m_n++;
                    if (m_n == 4) begin
                        m_valid[line_of(m_faddr)] = 1'b1;
                        m_line[line_of(m_faddr)]  = m_faddr / 32'd4;
                        m_data[line_of(m_faddr)]  = m_word;
                        m_busy = 1'b0;
                    end
                end
                if (jump_mistake) m_pc = jump_target;
            end else if (jump_mistake) begin
                m_pc = jump_target;
            end else if (model_hit(m_pc)) begin
                if (!stall[0]) m_pc = m_pc + 32'd4;
            end else begin
                m_busy = 1'b1;
                m_faddr = m_pc - (m_pc % 32'd4);
                m_n = 0;
                m_word = '0;
            end
        end
    end

    always @(negedge clk) begin : cmp_blk
        logic [31:0] e_pc, e_inst, e_addr;
        logic        e_sr, e_req;
        bit          v;
        if (rst) begin
            e_pc = '0; e_inst = '0; e_sr = 1'b0; e_req = 1'b0; e_addr = '0;
        end else begin
            v      = !m_busy && model_hit(m_pc);
            e_pc   = v ? m_pc : 32'h0;
            e_inst = v ? m_data[line_of(m_pc)] : 32'h0;
            e_sr   = !v;
            e_req  = m_busy;
            e_addr = m_faddr;
        end
        chk("model if_pc", if_pc, e_pc);
        chk("model if_inst", if_inst, e_inst);
        chk("model stall_req", 32'(stall_req), 32'(e_sr));
        chk("model mem_req", 32'(mem_req), 32'(e_req));
        chk("model mem_addr", mem_addr, e_addr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic give_bytes(input int n);
        drv_go = 1'b1;
        repeat (n) cyc();
        drv_go = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        jump_mistake = 1'b1;
        jump_target  = t;
        cyc();
        jump_mistake = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return 32'($urandom_range(63)) * 32'd4;
            1:       return 32'($urandom_range(3)) * 32'h200 + 32'($urandom_range(15)) * 32'd4;
            2:       return 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
            default: return 32'($urandom_range(255));
        endcase
    endfunction

    initial begin
        logic [STALL_LEN-1:0] s;
        repeat (3) cyc();
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset if_inst", if_inst, 32'h0);
        chk("reset stall_req", 32'(stall_req), 32'h0);
        chk("reset mem_req", 32'(mem_req), 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);

        // reset in the middle of a fill
        rst = 1'b0;
        cyc();
        chk("cold mem_req", 32'(mem_req), 32'h1);
        chk("cold mem_addr", mem_addr, 32'h0);
        give_bytes(2);
        rst = 1'b1;
        #1;
        chk("midrst mem_req", 32'(mem_req), 32'h0);
        chk("midrst if_inst", if_inst, 32'h0);
        chk("midrst stall_req", 32'(stall_req), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("refetch mem_req", 32'(mem_req), 32'h1);
        chk("refetch stall_req", 32'(stall_req), 32'h1);

        // cold miss at 0 fills 0x00100513
        give_bytes(4);
        chk("fill0 if_pc", if_pc, 32'h0);
        chk("fill0 if_inst", if_inst, 32'h0010_0513);
        chk("fill0 stall_req", 32'(stall_req), 32'h0);
        cyc();
        chk("pc4 miss stall_req", 32'(stall_req), 32'h1);

        // loop back to the warm line
        redirect(32'h0);
        chk("warm if_inst", if_inst, 32'h0010_0513);
        chk("warm mem_req", 32'(mem_req), 32'h0);

        // redirect during the fill of 0x8
        redirect(32'h8);
        cyc();
        chk("fetch8 mem_addr", mem_addr, 32'h8);
        give_bytes(1);
        redirect(32'h100);
        chk("drop mem_addr", mem_addr, 32'h8);
        chk("drop if_pc", if_pc, 32'h0);
        give_bytes(3);
        chk("drop done mem_req", 32'(mem_req), 32'h0);
        chk("drop done if_inst", if_inst, 32'h0);
        cyc();
        chk("newfetch mem_addr", mem_addr, 32'h100);
        give_bytes(4);
        chk("hit100 if_inst", if_inst, mem_word(32'h100));
        redirect(32'h8);
        chk("hit8 if_pc", if_pc, 32'h8);
        chk("hit8 if_inst", if_inst, mem_word(32'h8));

        // stall on a hit, then redirect beating stall
        redirect(32'h20);
        cyc();
        give_bytes(4);
        stall = STALL_LEN'(1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall if_pc", if_pc, 32'h20);
            chk("stall if_inst", if_inst, mem_word(32'h20));
        end
        stall = '0;
        cyc();
        chk("unstall stall_req", 32'(stall_req), 32'h1);
        stall = STALL_LEN'(1);
        redirect(32'h20);
        chk("jmp over stall if_pc", if_pc, 32'h20);
        redirect(32'h0);
        stall = '0;
        chk("jmp over stall2 if_inst", if_inst, 32'h0010_0513);

        // alias 0x200 over line 0, with rdy low mid-fill
        redirect(32'h200);
        chk("alias miss", 32'(stall_req), 32'h1);
        cyc();
        chk("alias mem_addr", mem_addr, 32'h200);
        give_bytes(2);
        rdy = 1'b0;
        drv_go = 1'b1;
        repeat (2) begin
            cyc();
            chk("rdy0 mem_req", 32'(mem_req), 32'h1);
            chk("rdy0 mem_addr", mem_addr, 32'h200);
        end
        rdy = 1'b1;
        give_bytes(2);
        chk("alias if_inst", if_inst, mem_word(32'h200));
        redirect(32'h0);
        chk("evicted stall_req", 32'(stall_req), 32'h1);
        cyc();
        give_bytes(4);
        chk("refill0 if_inst", if_inst, 32'h0010_0513);

        // pc wraps from the top of the address space
        redirect(32'hFFFF_FFFC);
        cyc();
        give_bytes(4);
        chk("top if_pc", if_pc, 32'hFFFF_FFFC);
        cyc();
        chk("wrap if_pc", if_pc, 32'h0);
        chk("wrap if_inst", if_inst, 32'h0010_0513);

        // random traffic
        drv_auto = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(9) != 0);
            s = STALL_LEN'($urandom);
            s[0] = ($urandom_range(4) == 0);
            stall = s;
            jump_mistake = ($urandom_range(19) == 0);
            jump_target = pick_target();
            if (c == 1500) rst = 1'b1;
            if (c == 1502) rst = 1'b0;
            cyc();
        end
        rdy = 1'b1;
        jump_mistake = 1'b0;
        stall = '0;
        repeat (4) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
